// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute stage: ALU operation codes and forwarding selects.
package ex_mem_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_sel_e;

    // EX/MEM wins over MEM/WB; register $0 is never forwarded.
    function automatic fwd_sel_e fwd_sel(input logic [4:0] src,
                                         input logic       mem_rw,
                                         input logic [4:0] mem_wr,
                                         input logic       wb_rw,
                                         input logic [4:0] wb_wr);
        if (mem_rw && mem_wr != 5'd0 && mem_wr == src) return FWD_MEM;
        if (wb_rw && wb_wr != 5'd0 && wb_wr == src)    return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/ex_mem_stage_alu_unit.sv
// Combinational ALU for the execute stage; unknown codes produce zero.
module alu_unit
    import ex_mem_stage_pkg::*;
(
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [4:0]  Shamt,
    input  logic [3:0]  ALUControl,
    output logic [31:0] Result,
    output logic        Zero
);

    always_comb begin
        Result = 32'd0;
        case (ALUControl)
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_ADD: Result = SrcA + SrcB;
            ALU_XOR: Result = SrcA ^ SrcB;
            ALU_SLL: Result = SrcB << Shamt;
            ALU_SRL: Result = SrcB >> Shamt;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_SLT: Result = {31'd0, $signed(SrcA) < $signed(SrcB)};
            ALU_NOR: Result = ~(SrcA | SrcB);
            default: Result = 32'd0;
        endcase
    end

    assign Zero = (Result == 32'd0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with branch/jump redirect and the EX/MEM pipeline register.
// Operand forwarding is built only when EX_FORWARD_EN is defined.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        MemWrite_in,
    input  logic        ALUSrc_in,
    input  logic        RegDst_in,
    input  logic        Branch_in,
    input  logic        Jump_in,
    input  logic [3:0]  ALUControl_in,
    input  logic [31:0] PC_in,
    input  logic [31:0] ReadData1_in,
    input  logic [31:0] ReadData2_in,
    input  logic [31:0] SignImm_in,
    input  logic [4:0]  Rs_in,
    input  logic [4:0]  Rt_in,
    input  logic [4:0]  Rd_in,
    input  logic [4:0]  Shamt_in,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg,
    input  logic [31:0] WB_Result,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic        MemWrite_out,
    output logic [31:0] ALUResult_out,
    output logic [31:0] WriteData_out,
    output logic [4:0]  WriteReg_out,
    output logic        Redirect,
    output logic [31:0] RedirectPC,
    output logic        Flush
);

    logic [31:0] opnd_a, opnd_b, src_b, alu_result;
    logic        alu_zero;
    logic [4:0]  write_reg;

`ifdef EX_FORWARD_EN
    fwd_sel_e sel_a, sel_b;

    assign sel_a = fwd_sel(Rs_in, RegWrite_out, WriteReg_out, WB_RegWrite, WB_WriteReg);
    assign sel_b = fwd_sel(Rt_in, RegWrite_out, WriteReg_out, WB_RegWrite, WB_WriteReg);

    always_comb begin
        opnd_a = ReadData1_in;
        opnd_b = ReadData2_in;
        case (sel_a)
            FWD_MEM: opnd_a = ALUResult_out;
            FWD_WB:  opnd_a = WB_Result;
            default: opnd_a = ReadData1_in;
        endcase
        case (sel_b)
            FWD_MEM: opnd_b = ALUResult_out;
            FWD_WB:  opnd_b = WB_Result;
            default: opnd_b = ReadData2_in;
        endcase
    end
`else
    // Without forwarding the hazard unit inserts bubbles; these inputs are dead.
    logic unused_fwd;
    assign unused_fwd = ^{WB_RegWrite, WB_WriteReg, WB_Result, Rs_in};
    assign opnd_a     = ReadData1_in;
    assign opnd_b     = ReadData2_in;
`endif

    assign src_b     = ALUSrc_in ? SignImm_in : opnd_b;
    assign write_reg = RegDst_in ? Rd_in : Rt_in;

    alu_unit u_alu (
        .SrcA       (opnd_a),
        .SrcB       (src_b),
        .Shamt      (Shamt_in),
        .ALUControl (ALUControl_in),
        .Result     (alu_result),
        .Zero       (alu_zero)
    );

    // Register jump takes precedence over a simultaneous branch.
    assign Redirect   = Jump_in | (Branch_in & alu_zero);
    assign RedirectPC = Jump_in ? opnd_a : (PC_in + 32'd4 + {SignImm_in[29:0], 2'b00});
    assign Flush      = Redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite_out  <= 1'b0;
            MemtoReg_out  <= 1'b0;
            MemWrite_out  <= 1'b0;
            ALUResult_out <= 32'd0;
            WriteData_out <= 32'd0;
            WriteReg_out  <= 5'd0;
        end else begin
            RegWrite_out  <= RegWrite_in;
            MemtoReg_out  <= MemtoReg_in;
            MemWrite_out  <= MemWrite_in;
            ALUResult_out <= alu_result;
            WriteData_out <= opnd_b;
            WriteReg_out  <= write_reg;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed vectors push expected EX/MEM contents,
// a monitor pops and compares one entry after every rising edge.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_in, MemtoReg_in, MemWrite_in, ALUSrc_in, RegDst_in, Branch_in, Jump_in;
    logic [3:0]  ALUControl_in;
    logic [31:0] PC_in, ReadData1_in, ReadData2_in, SignImm_in;
    logic [4:0]  Rs_in, Rt_in, Rd_in, Shamt_in;
    logic        WB_RegWrite;
    logic [4:0]  WB_WriteReg;
    logic [31:0] WB_Result;
    logic        RegWrite_out, MemtoReg_out, MemWrite_out;
    logic [31:0] ALUResult_out, WriteData_out;
    logic [4:0]  WriteReg_out;
    logic        Redirect, Flush;
    logic [31:0] RedirectPC;

`ifdef EX_FORWARD_EN
    localparam logic [31:0] E_FWD_SUB  = 32'd10;
    localparam logic [31:0] E_PRIO     = 32'd9;
    localparam logic [31:0] E_SW_DATA  = 32'd9;
    localparam logic [31:0] E_WB_ONLY  = 32'h33;
`else
    localparam logic [31:0] E_FWD_SUB  = 32'hFFFF_FFFE;
    localparam logic [31:0] E_PRIO     = 32'd0;
    localparam logic [31:0] E_SW_DATA  = 32'h55;
    localparam logic [31:0] E_WB_ONLY  = 32'd3;
`endif

    typedef struct {
        string       name;
        logic        rw, m2r, mw;
        logic [31:0] res, wd;
        logic [4:0]  wr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    ex_mem_stage dut (
        .clk(clk), .reset(reset),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in),
        .ALUSrc_in(ALUSrc_in), .RegDst_in(RegDst_in), .Branch_in(Branch_in), .Jump_in(Jump_in),
        .ALUControl_in(ALUControl_in), .PC_in(PC_in),
        .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in), .SignImm_in(SignImm_in),
        .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in), .Shamt_in(Shamt_in),
        .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_Result(WB_Result),
        .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .MemWrite_out(MemWrite_out),
        .ALUResult_out(ALUResult_out), .WriteData_out(WriteData_out), .WriteReg_out(WriteReg_out),
        .Redirect(Redirect), .RedirectPC(RedirectPC), .Flush(Flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        RegWrite_in = 0; MemtoReg_in = 0; MemWrite_in = 0; ALUSrc_in = 0; RegDst_in = 0;
        Branch_in = 0; Jump_in = 0; ALUControl_in = 4'b0000; PC_in = 0;
        ReadData1_in = 0; ReadData2_in = 0; SignImm_in = 0;
        Rs_in = 0; Rt_in = 0; Rd_in = 0; Shamt_in = 0;
        WB_RegWrite = 0; WB_WriteReg = 0; WB_Result = 0;
    endtask

    task automatic push(input string name, input logic rw, input logic m2r, input logic mw,
                        input logic [31:0] res, input logic [31:0] wd, input logic [4:0] wr);
        exp_t e;
        e.name = name; e.rw = rw; e.m2r = m2r; e.mw = mw; e.res = res; e.wd = wd; e.wr = wr;
        q.push_back(e);
    endtask

    // Set up ALU-only instruction with no forwarding-relevant sources.
    task automatic alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); clr();
        ALUControl_in = ctl; ReadData1_in = a; ReadData2_in = b; Rt_in = 5'd9;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".res"}, ALUResult_out, e.res);
                chk({e.name, ".wd"},  WriteData_out, e.wd);
                chk({e.name, ".wr"},  {27'd0, WriteReg_out}, {27'd0, e.wr});
                chk({e.name, ".ctl"}, {29'd0, RegWrite_out, MemtoReg_out, MemWrite_out},
                                      {29'd0, e.rw, e.m2r, e.mw});
            end
        end
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin : stim
        clr();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst.res", ALUResult_out, 32'd0);
        chk("rst.wd", WriteData_out, 32'd0);
        chk("rst.ctl", {24'd0, RegWrite_out, MemtoReg_out, MemWrite_out, WriteReg_out}, 32'd0);
        chk("rst.redirect", {31'd0, Redirect}, 32'd0);
        @(negedge clk); reset = 1'b0;

        // add $3 = 5 + 7
        @(negedge clk); clr();
        ALUControl_in = 4'b0010; ReadData1_in = 5; ReadData2_in = 7;
        RegDst_in = 1; Rd_in = 3; RegWrite_in = 1; Rs_in = 1; Rt_in = 2;
        push("add", 1, 0, 0, 32'd12, 32'd7, 5'd3);

        // sub with Rs=$3 depends on the add
        @(negedge clk); clr();
        ALUControl_in = 4'b0110; Rs_in = 3; Rt_in = 6; ReadData1_in = 0; ReadData2_in = 2;
        RegDst_in = 1; Rd_in = 8; RegWrite_in = 1;
        push("fwd_sub", 1, 0, 0, E_FWD_SUB, 32'd2, 5'd8);

        // writer targets $0, consumer must not forward
        @(negedge clk); clr();
        ALUControl_in = 4'b0010; ReadData1_in = 5; ReadData2_in = 7;
        RegDst_in = 1; Rd_in = 0; RegWrite_in = 1; Rs_in = 1; Rt_in = 2;
        push("add_r0", 1, 0, 0, 32'd12, 32'd7, 5'd0);
        @(negedge clk); clr();
        ALUControl_in = 4'b0110; Rs_in = 0; Rt_in = 6; ReadData1_in = 0; ReadData2_in = 2;
        push("nofwd_r0", 0, 0, 0, 32'hFFFF_FFFE, 32'd2, 5'd6);

        // priority: EX/MEM $4=9 vs WB $4=1
        @(negedge clk); clr();
        ALUControl_in = 4'b0010; ReadData1_in = 4; ReadData2_in = 5;
        RegDst_in = 1; Rd_in = 4; RegWrite_in = 1; Rs_in = 1; Rt_in = 2;
        push("add_r4", 1, 0, 0, 32'd9, 32'd5, 5'd4);
        @(negedge clk); clr();
        ALUControl_in = 4'b0001; Rs_in = 4; Rt_in = 0;
        WB_RegWrite = 1; WB_WriteReg = 4; WB_Result = 1;
        RegDst_in = 1; Rd_in = 7; RegWrite_in = 1;
        push("prio_or", 1, 0, 0, E_PRIO, 32'd0, 5'd7);

        // store: address = 0x100 + 8, data forwarded from $7
        @(negedge clk); clr();
        ALUControl_in = 4'b0010; ALUSrc_in = 1; SignImm_in = 8; MemWrite_in = 1;
        Rs_in = 0; ReadData1_in = 32'h100; Rt_in = 7; ReadData2_in = 32'h55;
        push("sw", 0, 0, 1, 32'h108, E_SW_DATA, 5'd7);

        // WB-only forwarding on Rs=$5; also a load-style control set
        @(negedge clk); clr();
        ALUControl_in = 4'b0010; Rs_in = 5; Rt_in = 0; ReadData1_in = 0; ReadData2_in = 3;
        WB_RegWrite = 1; WB_WriteReg = 5; WB_Result = 32'h30;
        RegWrite_in = 1; MemtoReg_in = 1; Rd_in = 12;
        push("wb_fwd", 1, 1, 0, E_WB_ONLY, 32'd3, 5'd0);

        alu(4'b0011, 32'h0000_F0F0, 32'h0000_0FF0); push("xor", 0, 0, 0, 32'h0000_FF00, 32'h0FF0, 5'd9);
        alu(4'b0100, 32'hDEAD_BEEF, 32'h1); Shamt_in = 4; push("sll", 0, 0, 0, 32'h10, 32'h1, 5'd9);
        alu(4'b0101, 32'h0, 32'h8000_0000); Shamt_in = 31; push("srl", 0, 0, 0, 32'h1, 32'h8000_0000, 5'd9);
        alu(4'b0111, 32'hFFFF_FFFF, 32'h1); push("slt_t", 0, 0, 0, 32'h1, 32'h1, 5'd9);
        alu(4'b0111, 32'h1, 32'hFFFF_FFFF); push("slt_f", 0, 0, 0, 32'h0, 32'hFFFF_FFFF, 5'd9);
        alu(4'b1100, 32'h0, 32'h0); push("nor", 0, 0, 0, 32'hFFFF_FFFF, 32'h0, 5'd9);
        alu(4'b1000, 32'h5, 32'h3); push("bad_op", 0, 0, 0, 32'h0, 32'h3, 5'd9);
        alu(4'b0000, 32'hFF, 32'h0F); push("and", 0, 0, 0, 32'h0F, 32'h0F, 5'd9);
        alu(4'b0010, 32'hFFFF_FFFF, 32'h2); push("add_wrap", 0, 0, 0, 32'h1, 32'h2, 5'd9);

        // taken branch: 0x100 + 4 - 8
        alu(4'b0110, 32'd7, 32'd7); Branch_in = 1; PC_in = 32'h100; SignImm_in = 32'hFFFF_FFFE;
        #1;
        chk("br.redirect", {31'd0, Redirect}, 32'd1);
        chk("br.flush", {31'd0, Flush}, 32'd1);
        chk("br.target", RedirectPC, 32'h0000_00FC);
        push("beq_t", 0, 0, 0, 32'h0, 32'd7, 5'd9);

        alu(4'b0110, 32'd7, 32'd8); Branch_in = 1; PC_in = 32'h100; SignImm_in = 32'hFFFF_FFFE;
        #1;
        chk("br_nt.redirect", {31'd0, Redirect}, 32'd0);
        chk("br_nt.flush", {31'd0, Flush}, 32'd0);
        push("beq_nt", 0, 0, 0, 32'hFFFF_FFFF, 32'd8, 5'd9);

        alu(4'b0010, 32'h0040_0020, 32'h0); Jump_in = 1; PC_in = 32'h200;
        #1;
        chk("jr.redirect", {31'd0, Redirect}, 32'd1);
        chk("jr.target", RedirectPC, 32'h0040_0020);
        push("jr", 0, 0, 0, 32'h0040_0020, 32'h0, 5'd9);

        // jump and taken branch together: jump target wins
        alu(4'b0110, 32'h0040_0020, 32'h0040_0020); Jump_in = 1; Branch_in = 1;
        PC_in = 32'h300; SignImm_in = 32'h10;
        #1;
        chk("jr_br.flush", {31'd0, Flush}, 32'd1);
        chk("jr_br.target", RedirectPC, 32'h0040_0020);
        push("jr_br", 0, 0, 0, 32'h0, 32'h0040_0020, 5'd9);

        // nonzero EX/MEM state, then reset mid-cycle
        @(negedge clk); clr();
        ALUControl_in = 4'b0001; ReadData1_in = 32'hA5; ReadData2_in = 32'h5A; ALUSrc_in = 0;
        RegDst_in = 1; Rd_in = 17; RegWrite_in = 1; MemtoReg_in = 1; MemWrite_in = 1;
        push("pre_rst", 1, 1, 1, 32'hFF, 32'h5A, 5'd17);
        @(posedge clk); #3;
        reset = 1'b1; #1;
        chk("arst.res", ALUResult_out, 32'd0);
        chk("arst.wd", WriteData_out, 32'd0);
        chk("arst.ctl", {24'd0, RegWrite_out, MemtoReg_out, MemWrite_out, WriteReg_out}, 32'd0);
        @(posedge clk); #1;
        chk("arst_hold.res", ALUResult_out, 32'd0);
        chk("arst_hold.ctl", {24'd0, RegWrite_out, MemtoReg_out, MemWrite_out, WriteReg_out}, 32'd0);
        @(negedge clk); reset = 1'b0; clr();
        push("post_rst", 0, 0, 0, 32'h0, 32'h0, 5'd0);

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs and applies operand forwarding. Performs the ALU operation and resolves branches and register jumps, raising a redirect/flush to the front end. Registers the result, store data, destination register and memory/writeback controls into the EX/MEM register feeding the MEM stage.

## Interface
Parameters:
- none (widths fixed: 32-bit data, 5-bit register index, 4-bit ALU control)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; clears the EX/MEM register
- RegWrite_in, MemtoReg_in, MemWrite_in, ALUSrc_in, RegDst_in, Branch_in, Jump_in  in  1 each  controls from ID/EX
- ALUControl_in  in  4  ALU operation
- PC_in  in  32  address of the EX instruction
- ReadData1_in, ReadData2_in  in  32  register operands
- SignImm_in  in  32  sign-extended immediate
- Rs_in, Rt_in, Rd_in, Shamt_in  in  5 each  register indices, shift amount
- WB_RegWrite  in  1  MEM/WB writes a register
- WB_WriteReg  in  5  MEM/WB destination
- WB_Result  in  32  MEM/WB writeback value
- RegWrite_out, MemtoReg_out, MemWrite_out  out  1 each  registered controls to MEM
- ALUResult_out  out  32  registered ALU result / memory address
- WriteData_out  out  32  registered store data (forwarded B operand)
- WriteReg_out  out  5  registered destination index
- Redirect  out  1  combinational: branch taken or jump in EX
- RedirectPC  out  32  combinational redirect target
- Flush  out  1  combinational, equals Redirect; drives IF/ID and ID/EX flush

## Operation
- Forwarding, per operand (A on Rs, B on Rt): if RegWrite_out && WriteReg_out!=0 && WriteReg_out==Rs/Rt, select ALUResult_out. Else if WB_RegWrite && WB_WriteReg!=0 && match, select WB_Result. Else select ReadData. EX/MEM has priority over MEM/WB. Load-use stalls are handled upstream.
- SrcB = ALUSrc_in ? SignImm_in : forwarded B. WriteData uses forwarded B only.
- ALUControl encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed), 1100 NOR.
  - SLL/SRL shift SrcB by Shamt_in.
  - Any other code yields 0.
  - ADD/SUB wrap modulo 2^32; no overflow trap.
- Zero = (ALU result == 0).
- Branch taken = Branch_in && Zero (beq semantics). Target = PC_in + 4 + (SignImm_in << 2), mod 2^32.
- Jump_in is a register jump: target = forwarded A. If Jump_in and Branch_in are both set, Jump wins.
- WriteReg = RegDst_in ? Rd_in : Rt_in.

## Timing
- EX/MEM register captures on every rising clk edge; there is no stall. Latency is 1 cycle from ID/EX outputs to the *_out ports.
- Reset is asynchronous: all registered outputs go to 0 immediately and stay 0 until the first edge after deassertion. Redirect/Flush are combinational, so they read 0 while the ID/EX contents are zero.
- Redirect, RedirectPC and Flush are valid in the same cycle the instruction is in EX. Fetch loads RedirectPC and IF/ID and ID/EX flush at the next edge, giving a 2-cycle taken-branch penalty.
- A redirecting instruction itself still enters EX/MEM. Jumps enter with RegWrite=0 because decode clears it.
- Back-to-back dependence: the EX/MEM value forwarded in cycle N is the result registered at edge N.
- Simultaneous EX/MEM and MEM/WB match: the EX/MEM value is used.

## Configuration
- EX_FORWARD_EN defined: forwarding muxes present as described.
- Not defined: operand A = ReadData1_in and operand B = ReadData2_in unconditionally, and the WB_* inputs are ignored. Software or the hazard unit must insert bubbles. Branch and jump targets use the unforwarded values.

## Structure
- The shared package holds the ALUControl code constants and the forwarding-select enum (FWD_REG, FWD_MEM, FWD_WB).
- One sub-module, alu_unit: combinational; inputs SrcA, SrcB, Shamt, ALUControl; outputs Result and Zero.
- Forwarding, redirect and the EX/MEM register stay in ex_mem_stage.

## Test plan
- ADD, no hazards: ReadData1=5, ReadData2=7, ALUControl=0010, RegDst=1, Rd=3 → after 1 edge ALUResult_out=12, WriteReg_out=3, RegWrite_out=1.
- EX/MEM forwarding: issue add $3=12, then sub with Rs=3, ReadData1=0, ReadData2=2 → ALUResult_out=10. Repeat with WriteReg=0 → result −2 (no forwarding from $0).
- Forwarding priority: EX/MEM $4=9 and WB $4=1 both valid, next instruction or with Rs=4, Rt=0 → ALUResult_out=9.
- Branch: PC=0x100, Branch=1, operands equal, SignImm=0xFFFFFFFE → Redirect=Flush=1 and RedirectPC=0x000000FC in the same cycle. With unequal operands → Redirect=0.
- Jump: Jump=1 with forwarded A=0x00400020 → RedirectPC=0x00400020. With Branch also set, the jump target is still used.
- Async reset: assert reset mid-cycle with a nonzero EX/MEM state → all *_out read 0 before the next clk edge and remain 0 while reset is high.
